// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard/forwarding controller (slave):
// decode-stage operands, forwarding taps, multi-cycle writeback and the resulting controls.
interface hazard_ctrl_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*5-1:0]      id_rs_sel;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [4:0]                id_rd;
  logic                      id_wb_en;
  logic                      id_is_mc;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_wb_en;
  logic [NUM_FWD-1:0]        fwd_data_rdy;
  logic [NUM_FWD*5-1:0]      fwd_rd;
  logic [NUM_FWD*XLEN-1:0]   fwd_data;
  logic                      mc_wb_valid;
  logic [4:0]                mc_wb_rd;
  logic                      flush;

  logic [NUM_SRC-1:0]        fwd_en;
  logic [NUM_SRC*XLEN-1:0]   fwd_data_out;
  logic                      stall_if;
  logic                      stall_ifof;
  logic                      stall_ofex;
  logic                      stall_exmem;
  logic                      stall_memwb;
  logic                      bubble_ex;
  logic [31:0]               sb_pending;
  logic                      mc_busy;
  logic                      sb_error;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_rs_sel, id_rs_used, id_rd, id_wb_en, id_is_mc,
    output fwd_valid, fwd_wb_en, fwd_data_rdy, fwd_rd, fwd_data,
    output mc_wb_valid, mc_wb_rd, flush,
    input  fwd_en, fwd_data_out, stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb,
    input  bubble_ex, sb_pending, mc_busy, sb_error, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_sel, id_rs_used, id_rd, id_wb_en, id_is_mc,
    input  fwd_valid, fwd_wb_en, fwd_data_rdy, fwd_rd, fwd_data,
    input  mc_wb_valid, mc_wb_rd, flush,
    output fwd_en, fwd_data_out, stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb,
    output bubble_ex, sb_pending, mc_busy, sb_error, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection, operand forwarding and multi-cycle scoreboard for the OF stage.
// Hazards are purely combinational; forwarding overrides for EX are registered.
module hazard_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic          clk,
  input logic          resetn,
  hazard_ctrl_if.slave bus
);
  logic [4:0]              rs       [NUM_SRC];
  logic [XLEN-1:0]         src_data [NUM_SRC];
  logic [NUM_SRC-1:0]      src_act;
  logic [NUM_SRC-1:0]      src_hit;
  logic [NUM_SRC-1:0]      src_rdy;
  logic                    load_use, raw, waw, structural, hz, issue;

  logic [NUM_SRC-1:0]      fwd_en_d, fwd_en_q;
  logic [NUM_SRC*XLEN-1:0] fwd_data_d, fwd_data_q;
  logic [31:0]             sb_d, sb_q;
  logic                    mc_busy_d, mc_busy_q;
  logic                    sb_err_d, sb_err_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;

  always_comb begin
    load_use = 1'b0;
    raw      = 1'b0;
    src_act  = '0;
    src_hit  = '0;
    src_rdy  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      rs[s]       = bus.id_rs_sel[5*s +: 5];
      src_data[s] = '0;
      src_act[s]  = bus.id_valid && bus.id_rs_used[s] && (rs[s] != 5'd0);
      // Scan oldest to youngest so the youngest matching stage overrides.
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (bus.fwd_valid[i] && bus.fwd_wb_en[i] && (bus.fwd_rd[5*i +: 5] == rs[s])) begin
          src_hit[s]  = 1'b1;
          src_rdy[s]  = bus.fwd_data_rdy[i];
          src_data[s] = bus.fwd_data[XLEN*i +: XLEN];
        end
      end
      if (src_act[s] && src_hit[s] && !src_rdy[s]) load_use = 1'b1;
      // Uses the registered scoreboard, so a same-cycle writeback still stalls.
      if (src_act[s] && sb_q[rs[s]]) raw = 1'b1;
    end
    waw        = bus.id_valid && bus.id_wb_en && (bus.id_rd != 5'd0) && sb_q[bus.id_rd];
    structural = bus.id_valid && bus.id_is_mc && mc_busy_q;
    hz         = (load_use || raw || waw || structural) && !bus.flush;
    issue      = bus.id_valid && !hz && !bus.flush;
  end

  always_comb begin
    fwd_en_d   = '0;
    fwd_data_d = fwd_data_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (issue && src_act[s] && src_hit[s]) begin
        fwd_en_d[s]                  = 1'b1;
        fwd_data_d[XLEN*s +: XLEN]   = src_data[s];
      end
    end

    sb_d      = sb_q;
    mc_busy_d = mc_busy_q;
    if (bus.mc_wb_valid) begin
      sb_d[bus.mc_wb_rd] = 1'b0;
      mc_busy_d          = 1'b0;
    end
    if (issue && bus.id_is_mc) begin
      mc_busy_d = 1'b1;
      if (bus.id_wb_en && (bus.id_rd != 5'd0)) sb_d[bus.id_rd] = 1'b1;
    end

    sb_err_d = sb_err_q || (bus.mc_wb_valid && !sb_q[bus.mc_wb_rd] && !mc_busy_q);

    cnt_d = cnt_q;
    if (hz && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_en_q   <= '0;
      fwd_data_q <= '0;
      sb_q       <= '0;
      mc_busy_q  <= 1'b0;
      sb_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      fwd_en_q   <= fwd_en_d;
      fwd_data_q <= fwd_data_d;
      sb_q       <= sb_d;
      mc_busy_q  <= mc_busy_d;
      sb_err_q   <= sb_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.fwd_en       = fwd_en_q;
  assign bus.fwd_data_out = fwd_data_q;
  assign bus.stall_if     = hz;
  assign bus.stall_ifof   = hz;
  assign bus.bubble_ex    = hz;
  assign bus.stall_ofex   = 1'b0;
  assign bus.stall_exmem  = 1'b0;
  assign bus.stall_memwb  = 1'b0;
  assign bus.sb_pending   = sb_q;
  assign bus.mc_busy      = mc_busy_q;
  assign bus.sb_error     = sb_err_q;
  assign bus.stall_cnt    = cnt_q;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction (1..3).
REQ-003 SHALL have parameter NUM_FWD, default 2, meaning forwarding stages; index 0 is youngest (EX out), index NUM_FWD-1 is oldest.
REQ-004 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 clk  in  1  the only clock; all state updates on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  instruction present at OF output.
REQ-008 id_rs_sel  in  NUM_SRC*5  source register indices, source s at bits [5s+4:5s].
REQ-009 id_rs_used  in  NUM_SRC  per-source "operand read" flags.
REQ-010 id_rd, id_wb_en, id_is_mc  in  5, 1, 1  destination, writeback enable, multi-cycle (mul/div) op.
REQ-011 fwd_valid, fwd_wb_en, fwd_data_rdy  in  NUM_FWD each  per-stage valid, writes rd, result available (0 = load not yet returned).
REQ-012 fwd_rd, fwd_data  in  NUM_FWD*5, NUM_FWD*XLEN  per-stage destination and result.
REQ-013 mc_wb_valid, mc_wb_rd  in  1, 5  multi-cycle unit writeback.
REQ-014 flush  in  1  kill the instruction at OF.
REQ-015 fwd_en, fwd_data_out  out  NUM_SRC, NUM_SRC*XLEN  registered operand overrides for EX.
REQ-016 stall_if, stall_ifof, stall_ofex, stall_exmem, stall_memwb, bubble_ex  out  1 each  pipeline controls.
REQ-017 sb_pending  out  32  scoreboard of registers awaiting multi-cycle writeback.
REQ-018 mc_busy, sb_error  out  1 each  multi-cycle unit occupied; sticky protocol error.
REQ-019 stall_cnt  out  CNT_W  hazard-stall cycle count.

Function
REQ-020 Source s SHALL be active when id_valid && id_rs_used[s] && id_rs_sel[s]!=0; x0 never hazards or forwards.
REQ-021 Per active source, the match SHALL be the lowest index i with fwd_valid[i] && fwd_wb_en[i] && fwd_rd[i]==rs; younger stage wins.
REQ-022 Matched stage with fwd_data_rdy[i]==0 SHALL raise load-use hazard.
REQ-023 Active source with sb_pending[rs]==1 SHALL raise RAW hazard, even if mc_wb_valid clears it in the same cycle.
REQ-024 id_valid && id_wb_en && id_rd!=0 && sb_pending[id_rd] SHALL raise WAW hazard.
REQ-025 id_valid && id_is_mc && mc_busy SHALL raise structural hazard.
REQ-026 hz = OR of REQ-022..025 && !flush; all hazard logic combinational, same cycle.
REQ-027 stall_if=stall_ifof=bubble_ex=hz; stall_ofex=stall_exmem=stall_memwb=0.
REQ-028 issue = id_valid && !hz && !flush.
REQ-029 On issue, next-cycle fwd_en[s]/fwd_data_out[s] SHALL be the matched stage's data with fwd_en=1, else fwd_en=0 with data held.
REQ-030 On hz or flush, next-cycle fwd_en SHALL be all 0 with data held; otherwise (no id_valid) fwd_en SHALL be 0.
REQ-031 Issue with id_is_mc && id_wb_en && id_rd!=0 SHALL set sb_pending[id_rd]; issue with id_is_mc SHALL set mc_busy.
REQ-032 mc_wb_valid SHALL clear sb_pending[mc_wb_rd] and mc_busy; set and clear are the same cycle only for different registers.
REQ-033 mc_wb_valid with sb_pending[mc_wb_rd]==0 and mc_busy==0 SHALL set sb_error, held until reset.
REQ-034 flush SHALL NOT clear sb_pending or mc_busy (in-flight op completes).
REQ-035 stall_cnt SHALL increment each cycle hz==1, saturating at all ones.

Reset
REQ-036 resetn low SHALL immediately clear fwd_en, fwd_data_out, sb_pending, mc_busy, sb_error, stall_cnt to 0; combinational stalls follow inputs.
REQ-037 Reset mid multi-cycle op SHALL discard scoreboard state; a later stray mc_wb_valid sets sb_error.

Verification
REQ-038 fwd0: valid, rd=5, rdy=1, data=0xAA; fwd1: rd=5, data=0xBB; id rs1=5 -> next cycle fwd_en[0]=1, fwd_data_out[0]=0xAA.
REQ-039 fwd0 rd=7, rdy=0 (load); id rs2=7 -> hz=1, bubble_ex=1, stall_cnt+1; next cycle rdy=1 -> issue, fwd_en[1]=1.
REQ-040 Issue mc rd=9; next id rs1=9 stalls until mc_wb_valid rd=9, then issues one cycle later; sb_pending[9] 1->0.
REQ-041 mc_busy=1, id_is_mc=1 -> stall; flush same cycle -> hz=0, fwd_en=0, mc_busy stays 1.
REQ-042 rs1=0 with fwd0 rd=0 rdy=0 -> no stall, fwd_en[0]=0; mc_wb_valid rd=3 when idle -> sb_error=1.
REQ-043 stall_cnt at 0xFFFF with CNT_W=16 and hz=1 -> holds 0xFFFF; resetn low -> 0 asynchronously.
